// File: rtl/mem_resp_unit.sv
// Word-addressed memory responder with fixed latency and valid/ready ports.
// Optional MEM_BYTE_MASK_EN adds req_be byte enables for stores.
module mem_resp_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
`ifdef MEM_BYTE_MASK_EN
  input  logic [3:0]            req_be,
`endif
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int NB    = DATA_WIDTH / 8;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    we_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   rd_q;
  logic [DATA_WIDTH-1:0]   mem [WORDS];

  logic [DEPTH_LOG2-1:0]   idx;
  logic                    misal;
  logic                    accept;
  logic [NB-1:0]           be_eff;

  assign idx    = req_addr[DEPTH_LOG2+1:2];
  assign misal  = |req_addr[1:0];
  assign accept = req_valid & req_ready & ~reset;

`ifdef MEM_BYTE_MASK_EN
  assign be_eff = req_be;
`else
  assign be_eff = '1;
`endif

  // Upper address bits only wrap the index; keep them visibly unused.
  logic unused_addr;
  assign unused_addr = ^req_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];

  // Storage is never reset; stores commit at the accepting edge.
  always_ff @(posedge clk) begin
    if (accept && req_we && !misal) begin
      for (int b = 0; b < NB; b++) begin
        if (be_eff[b]) begin
          mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
    if (accept && !req_we) begin
      rd_q <= mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cnt        <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= WAIT;
            req_ready <= 1'b0;
            cnt       <= LAT_INIT;
            we_q      <= req_we;
            err_q     <= misal;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= (we_q | err_q) ? '0 : rd_q;
            resp_err   <= err_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_resp_unit.sv
// Self-checking bench for mem_resp_unit: vector table plus reset corner cases.
// Expected responses flow through a scoreboard queue.
module tb_mem_resp_unit;

  localparam int LAT = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
`ifdef MEM_BYTE_MASK_EN
  logic [3:0]  req_be;
`endif
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];
  vec_t vt[15];

  always #5 clk = ~clk;

  mem_resp_unit #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .DEPTH_LOG2(8),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
`ifdef MEM_BYTE_MASK_EN
    .req_be(req_be),
`endif
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
`ifdef MEM_BYTE_MASK_EN
    req_be    = be;
`else
    if (be == 4'hx) req_we = we;
`endif
  endtask

  task automatic scramble();
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic accept_only(input logic we, input logic [31:0] addr,
                             input logic [31:0] wd);
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    drive(we, addr, wd, 4'hF);
    tick();
    scramble();
  endtask

  task automatic xact(input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic [31:0] er, input logic ee,
                      input int hold);
    exp_t e;
    int   lat;
    bit   seen;
    sb.push_back('{er, ee});
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    drive(we, addr, wd, be);
    tick();
    scramble();
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      tick();
      lat++;
      if (resp_valid) seen = 1'b1;
    end
    e = sb.pop_front();
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL resp_timeout: addr %h no resp_valid in 20 cycles",
               addr);
    end else begin
      chk("latency", 32'(lat), 32'(LAT));
      chk("rdata", resp_rdata, e.rdata);
      chk("err", 32'(resp_err), 32'(e.err));
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_rdata", resp_rdata, e.rdata);
        chk("hold_ready", 32'(req_ready), 32'd0);
      end
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("post_valid", 32'(resp_valid), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
    chk("post_rdata", resp_rdata, 32'd0);
    chk("post_err", 32'(resp_err), 32'd0);
  endtask

  task automatic watch_quiet(input int n);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (resp_valid) hits++;
    end
    chk("no_stale_resp", 32'(hits), 32'd0);
  endtask

  initial begin
    logic [31:0] m1;
    logic [31:0] m2;
`ifdef MEM_BYTE_MASK_EN
    m1 = 32'h11BB33DD;
    m2 = 32'h11BB33DD;
`else
    m1 = 32'hAABBCCDD;
    m2 = 32'h55555555;
`endif
    vt[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 0};
    vt[1]  = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 0};
    vt[2]  = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 5};
    vt[3]  = '{1'b1, 32'h11,       32'h12345678, 4'hF, 32'h0,        1'b1, 0};
    vt[4]  = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 0};
    vt[5]  = '{1'b1, 32'h400,      32'hA5A5A5A5, 4'hF, 32'h0,        1'b0, 0};
    vt[6]  = '{1'b0, 32'h000,      32'h0,        4'hF, 32'hA5A5A5A5, 1'b0, 0};
    vt[7]  = '{1'b1, 32'h3FC,      32'h0F0F0F0F, 4'hF, 32'h0,        1'b0, 0};
    vt[8]  = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'hF, 32'h0F0F0F0F, 1'b0, 1};
    vt[9]  = '{1'b0, 32'h13,       32'h0,        4'hF, 32'h0,        1'b1, 2};
    vt[10] = '{1'b1, 32'h8,        32'h11223344, 4'hF, 32'h0,        1'b0, 0};
    vt[11] = '{1'b1, 32'h8,        32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 0};
    vt[12] = '{1'b0, 32'h8,        32'h0,        4'hF, m1,           1'b0, 0};
    vt[13] = '{1'b1, 32'h8,        32'h55555555, 4'h0, 32'h0,        1'b0, 0};
    vt[14] = '{1'b0, 32'h8,        32'h0,        4'hF, m2,           1'b0, 0};

    reset      = 1'b1;
    resp_ready = 1'b0;
    scramble();
`ifdef MEM_BYTE_MASK_EN
    req_be = 4'hF;
`endif
    tick();
    tick();
    reset = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);

    foreach (vt[i]) begin
      xact(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be,
           vt[i].rdata, vt[i].err, vt[i].hold);
    end

    // store accepted, then reset during WAIT: write survives
    accept_only(1'b1, 32'h2C, 32'hCAFEF00D);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstwait_st_ready", 32'(req_ready), 32'd1);
    chk("rstwait_st_valid", 32'(resp_valid), 32'd0);
    watch_quiet(5);
    xact(1'b0, 32'h2C, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 0);

    // load accepted, reset during WAIT: response dropped
    accept_only(1'b0, 32'h20, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstwait_ld_ready", 32'(req_ready), 32'd1);
    chk("rstwait_ld_valid", 32'(resp_valid), 32'd0);
    watch_quiet(5);

    // reset while in RESP
    accept_only(1'b0, 32'h10, 32'h0);
    tick();
    tick();
    chk("rstresp_pre_valid", 32'(resp_valid), 32'd1);
    chk("rstresp_pre_rdata", resp_rdata, 32'hDEADBEEF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstresp_valid", 32'(resp_valid), 32'd0);
    chk("rstresp_rdata", resp_rdata, 32'd0);
    chk("rstresp_ready", 32'(req_ready), 32'd1);
    watch_quiet(4);

    // request coincident with reset is ignored
    xact(1'b1, 32'h24, 32'h00001111, 4'hF, 32'h0, 1'b0, 0);
    reset = 1'b1;
    drive(1'b1, 32'h24, 32'h00002222, 4'hF);
    tick();
    reset = 1'b0;
    scramble();
    chk("rstreq_ready", 32'(req_ready), 32'd1);
    watch_quiet(4);
    xact(1'b0, 32'h24, 32'h0, 4'hF, 32'h00001111, 1'b0, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
